ir_command_decoder: RTL

//  Consumes decoded NEC frames from the IR receiver and produces a validated, held one-hot drive command for MotorControl.

---
 rtl/ir_command_decoder_pkg.sv | 43 ++++
 rtl/ir_command_decoder_if.sv | 23 ++
 rtl/ir_command_decoder_hold_timer.sv | 27 ++
 rtl/ir_command_decoder.sv | 129 ++++++++++++
 4 files changed

// File: rtl/ir_command_decoder_pkg.sv
// Shared IR command definitions: NEC key codes, one-hot drive bit indices and the
// key-to-command mapping, also used by the motor controller.
package ir_command_decoder_pkg;

  localparam logic [7:0] KEY_SPEED_UP   = 8'h1A;
  localparam logic [7:0] KEY_CMD1       = 8'h02;
  localparam logic [7:0] KEY_CMD3       = 8'h04;
  localparam logic [7:0] KEY_CMD4       = 8'h05;
  localparam logic [7:0] KEY_CMD5       = 8'h06;
  localparam logic [7:0] KEY_SPEED_DOWN = 8'h1E;
  localparam logic [7:0] KEY_CMD7       = 8'h08;

  // Bit 2 is reserved and never driven.
  localparam int unsigned BIT_SPEED_UP   = 0;
  localparam int unsigned BIT_CMD1       = 1;
  localparam int unsigned BIT_CMD3       = 3;
  localparam int unsigned BIT_CMD4       = 4;
  localparam int unsigned BIT_CMD5       = 5;
  localparam int unsigned BIT_SPEED_DOWN = 6;
  localparam int unsigned BIT_CMD7       = 7;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  function automatic logic [7:0] key_to_onehot(input logic [7:0] key);
    logic [7:0] oh;
    oh = '0;
    case (key)
      KEY_SPEED_UP:   oh[BIT_SPEED_UP]   = 1'b1;
      KEY_CMD1:       oh[BIT_CMD1]       = 1'b1;
      KEY_CMD3:       oh[BIT_CMD3]       = 1'b1;
      KEY_CMD4:       oh[BIT_CMD4]       = 1'b1;
      KEY_CMD5:       oh[BIT_CMD5]       = 1'b1;
      KEY_SPEED_DOWN: oh[BIT_SPEED_DOWN] = 1'b1;
      KEY_CMD7:       oh[BIT_CMD7]       = 1'b1;
      default:        oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/ir_command_decoder_if.sv
// Frame input / command output bundle between the IR receiver side and the decoder.
interface ir_command_decoder_if;
  import ir_command_decoder_pkg::*;

  logic        frame_valid;
  logic [31:0] frame_data;
  logic [7:0]  cmd_onehot;
  logic        cmd_valid;
  logic        cmd_active;
  logic        frame_error;
  logic [7:0]  err_count;

  modport master (
    output frame_valid, frame_data,
    input  cmd_onehot, cmd_valid, cmd_active, frame_error, err_count
  );

  modport slave (
    input  frame_valid, frame_data,
    output cmd_onehot, cmd_valid, cmd_active, frame_error, err_count
  );

endinterface

// File: rtl/ir_command_decoder_hold_timer.sv
// Hold-time down-counter: load wins over decrement, and it stops at zero.
module ir_command_decoder_hold_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ir_command_decoder.sv
// Validates decoded NEC frames and turns them into a held one-hot drive command,
// released when repeat frames stop arriving for HOLD_CYCLES clocks.
module ir_command_decoder
  import ir_command_decoder_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 7_500_000,
  parameter bit          ADDR_CHECK  = 1'b0,
  parameter logic [15:0] ADDR_VALUE  = 16'h0000
) (
  input  logic                 clk,
  input  logic                 rst,
  ir_command_decoder_if.slave  bus
);

  localparam int unsigned     TW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [TW-1:0]   HOLD_LOAD = TW'(HOLD_CYCLES - 1);

  logic       strobe_q;
  logic       ok_q;
  logic [7:0] key_q;

  state_t     state_q;
  logic [7:0] cmd_q;
  logic       cmd_valid_q;
  logic       cmd_active_q;
  logic       frame_error_q;
  logic [7:0] err_count_q;

  logic       frame_ok;
  logic [7:0] oh;
  logic       mapped;
  logic       timer_load;
  logic       timer_dec;
  logic       timer_zero;
  logic       ok_d;

  always_comb begin
    ok_d = (bus.frame_data[31:24] == ~bus.frame_data[23:16]) &&
           (!ADDR_CHECK || (bus.frame_data[15:0] == ADDR_VALUE));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      strobe_q <= 1'b0;
      ok_q     <= 1'b0;
      key_q    <= '0;
    end else begin
      strobe_q <= bus.frame_valid;
      if (bus.frame_valid) begin
        ok_q  <= ok_d;
        key_q <= bus.frame_data[23:16];
      end
    end
  end

  // A rejected frame counts as "no frame" for the hold timer, so it cannot block a release.
  always_comb begin
    oh         = key_to_onehot(key_q);
    mapped     = (oh != '0);
    frame_ok   = strobe_q && ok_q;
    timer_load = frame_ok && mapped;
    timer_dec  = (state_q == ACTIVE) && !frame_ok && !timer_zero;
  end

  ir_command_decoder_hold_timer #(.W(TW)) u_hold_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (timer_load),
    .load_val_i (HOLD_LOAD),
    .dec_i      (timer_dec),
    .zero_o     (timer_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cmd_q         <= '0;
      cmd_valid_q   <= 1'b0;
      cmd_active_q  <= 1'b0;
      frame_error_q <= 1'b0;
      err_count_q   <= '0;
    end else begin
      cmd_valid_q   <= 1'b0;
      frame_error_q <= 1'b0;
      if (strobe_q && !ok_q) begin
        frame_error_q <= 1'b1;
        if (err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
      end
      case (state_q)
        IDLE: begin
          if (frame_ok && mapped) begin
            state_q      <= ACTIVE;
            cmd_q        <= oh;
            cmd_valid_q  <= 1'b1;
            cmd_active_q <= 1'b1;
          end
        end
        ACTIVE: begin
          if (frame_ok) begin
            if (!mapped) begin
              state_q      <= IDLE;
              cmd_q        <= '0;
              cmd_active_q <= 1'b0;
            end else if (oh != cmd_q) begin
              cmd_q       <= oh;
              cmd_valid_q <= 1'b1;
            end
          end else if (timer_zero) begin
            state_q      <= IDLE;
            cmd_q        <= '0;
            cmd_active_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= IDLE;
          cmd_q        <= '0;
          cmd_active_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_onehot  = cmd_q;
  assign bus.cmd_valid   = cmd_valid_q;
  assign bus.cmd_active  = cmd_active_q;
  assign bus.frame_error = frame_error_q;
  assign bus.err_count   = err_count_q;

endmodule
